// File: rtl/argmax_letter_decoder.sv
// argmax_letter_decoder: clocked, back-pressurable argmax stage for the final
// dense layer. Scores arrive one per cycle, are ReLU-clamped, and the winning
// class index is presented with its ASCII letter ('A' for class 0).
module argmax_letter_decoder #(
    parameter int unsigned DBW         = 234,
    parameter int unsigned NUM_CLASSES = 26,
    parameter int unsigned IDXW        = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DBW:0]      in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW-1:0]   out_index,
    output logic [7:0]        out_letter,
    output logic [DBW:0]      out_max,
    output logic              out_err
);

    localparam int unsigned NUM_LETTERS = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state;
    logic [IDXW-1:0]     cnt;
    logic [IDXW-1:0]     run_idx;
    logic signed [DBW:0] run_max;

    logic signed [DBW:0] val;
    logic signed [DBW:0] nxt_max;
    logic [IDXW-1:0]     nxt_idx;
    logic                upd;
    logic                cnt_end;
    logic                close_vec;
    logic                len_err;
    logic                accept;

    // Class index to ASCII letter; indices beyond 'Z' map to '?'
    function automatic logic [7:0] letter_of(input logic [IDXW-1:0] idx);
        if (32'(idx) < 32'(NUM_LETTERS)) begin
            return 8'h41 + 8'(idx);
        end
        return 8'h3F;
    endfunction

    // Ready whenever no result is pending; forced low while in reset
    assign in_ready = ~rst & (state != HOLD);
    assign accept   = in_valid & (state != HOLD);

    // ReLU clamp, strict-greater compare (ties keep the lower index), close detect
    always_comb begin
        val       = in_data[DBW] ? '0 : $signed(in_data);
        upd       = (val > run_max);
        nxt_max   = upd ? val : run_max;
        nxt_idx   = upd ? cnt : run_idx;
        cnt_end   = (cnt == IDXW'(NUM_CLASSES - 1));
        close_vec = in_last | cnt_end;
        len_err   = in_last ^ cnt_end;
    end

    // Scan/hold state machine with registered result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            run_idx    <= '0;
            run_max    <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_letter <= '0;
            out_max    <= '0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE, SCAN: begin
                    if (accept) begin
                        if (close_vec) begin
                            state      <= HOLD;
                            out_valid  <= 1'b1;
                            out_index  <= nxt_idx;
                            out_letter <= letter_of(nxt_idx);
                            out_max    <= nxt_max;
                            out_err    <= len_err;
                            cnt        <= '0;
                            run_idx    <= '0;
                            run_max    <= '0;
                        end else begin
                            state   <= SCAN;
                            cnt     <= cnt + IDXW'(1);
                            run_idx <= nxt_idx;
                            run_max <= nxt_max;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_letter_decoder.sv
// Testbench for argmax_letter_decoder: directed scenarios plus randomized
// vectors checked against a simple array-based argmax reference.
module tb_argmax_letter_decoder;

    localparam int unsigned DBW  = 234;
    localparam int unsigned NC   = 26;
    localparam int unsigned IDXW = 6;

    typedef logic signed [DBW:0] sc_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DBW:0]    in_data = '0;
    logic            in_last = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [IDXW-1:0] out_index;
    logic [7:0]      out_letter;
    logic [DBW:0]    out_max;
    logic            out_err;

    int tests = 0;
    int fails = 0;
    string abc = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";

    argmax_letter_decoder #(.DBW(DBW), .NUM_CLASSES(NC), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_letter(out_letter), .out_max(out_max), .out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic sc_t small_score(input int lo, input int hi);
        int v;
        v = lo + int'($urandom_range(32'(hi - lo)));
        return sc_t'(v);
    endfunction

    function automatic sc_t wide_score();
        logic [255:0] t;
        for (int k = 0; k < 8; k++) t[k*32 +: 32] = $urandom();
        return sc_t'(t[DBW:0]);
    endfunction

    // Drive one vector, check the result against the reference, optionally stall
    // the consumer for 'hold' cycles with upstream pushing, then release it.
    task automatic run_vec(input string name, input sc_t sc[$], input bit lst[$], input int hold);
        int   close_i;
        int   exp_idx;
        sc_t  exp_max;
        bit   exp_err;
        logic [7:0] exp_let;
        sc_t  v;
        int   guard;
        // reference: vector ends at the first in_last or the 26th element
        close_i = sc.size() - 1;
        for (int i = 0; i < sc.size(); i++) begin
            if (lst[i] || i == NC - 1) begin close_i = i; break; end
        end
        exp_idx = 0; exp_max = '0;
        for (int i = 0; i <= close_i; i++) begin
            v = (sc[i] < 0) ? sc_t'(0) : sc[i];
            if (v > exp_max) begin exp_max = v; exp_idx = i; end
        end
        exp_err = (lst[close_i] != (close_i == NC - 1));
        exp_let = (exp_idx < 26) ? abc[exp_idx] : 8'h3F;

        for (int i = 0; i <= close_i; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = sc[i]; in_last = lst[i];
            guard = 0;
            while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
            if (guard >= 50) begin
                tests++; fails++;
                $display("FAIL %s: in_ready timeout at element %0d", name, i);
            end
            if (i == close_i) begin
                tests++;
                if (out_valid !== 1'b0) begin
                    fails++; $display("FAIL %s early_valid: out_valid=%b need 0", name, out_valid);
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fails++; $display("FAIL %s latency: out_valid=%b in_ready=%b need 1 0", name, out_valid, in_ready);
        end
        tests++;
        if (out_index !== IDXW'(exp_idx) || out_letter !== exp_let) begin
            fails++; $display("FAIL %s index: idx=%0d letter=%h need %0d %h", name, out_index, out_letter, exp_idx, exp_let);
        end
        tests++;
        if (out_max !== exp_max) begin
            fails++; $display("FAIL %s max: got %0d need %0d", name, out_max, exp_max);
        end
        tests++;
        if (out_err !== exp_err) begin
            fails++; $display("FAIL %s err: got %b need %b", name, out_err, exp_err);
        end
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'b1; in_data = small_score(-20, 200); in_last = c[0];
            @(negedge clk);
            tests++;
            if ({out_valid, in_ready, out_index, out_letter, out_err} !== {1'b1, 1'b0, IDXW'(exp_idx), exp_let, exp_err}
                || out_max !== exp_max) begin
                fails++; $display("FAIL %s stall c%0d: v=%b rdy=%b idx=%0d max=%0d need 1 0 %0d %0d",
                                  name, c, out_valid, in_ready, out_index, out_max, exp_idx, exp_max);
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL %s release: out_valid=%b in_ready=%b need 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if ({in_ready, out_valid, out_index, out_letter, out_err} !== '0 || out_max !== '0) begin
            fails++; $display("FAIL reset_values: rdy=%b v=%b idx=%0d let=%h err=%b max=%0d need all 0",
                              in_ready, out_valid, out_index, out_letter, out_err, out_max);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release: in_ready=%b need 1", in_ready);
        end
    endtask

    task automatic test_ascending();
        sc_t sc[$]; bit lst[$];
        for (int i = 0; i < NC; i++) begin sc.push_back(sc_t'(i)); lst.push_back(i == NC - 1); end
        run_vec("ascending", sc, lst, 0);
    endtask

    task automatic test_tie();
        sc_t sc[$]; bit lst[$];
        for (int i = 0; i < NC; i++) begin
            sc.push_back((i == 3 || i == 7) ? sc_t'(100) : sc_t'(5)); lst.push_back(i == NC - 1);
        end
        run_vec("tie", sc, lst, 0);
    endtask

    task automatic test_all_negative();
        sc_t sc[$]; bit lst[$];
        for (int i = 0; i < NC; i++) begin sc.push_back(sc_t'(-9)); lst.push_back(i == NC - 1); end
        run_vec("all_negative", sc, lst, 0);
    endtask

    task automatic test_length_err();
        sc_t sc[$]; bit lst[$];
        for (int i = 0; i < 5; i++) begin
            sc.push_back(i == 2 ? sc_t'(1000) : small_score(-100, 900)); lst.push_back(i == 4);
        end
        run_vec("early_last", sc, lst, 0);
        sc.delete(); lst.delete();
        for (int i = 0; i < NC; i++) begin sc.push_back(small_score(-300, 300)); lst.push_back(1'b0); end
        run_vec("missing_last", sc, lst, 0);
    endtask

    task automatic test_backpressure();
        sc_t sc[$]; bit lst[$];
        for (int i = 0; i < NC; i++) begin sc.push_back(small_score(-50, 50)); lst.push_back(i == NC - 1); end
        run_vec("backpressure", sc, lst, 10);
        sc.delete(); lst.delete();
        sc.push_back(sc_t'(3)); sc.push_back(sc_t'(9)); sc.push_back(sc_t'(1));
        lst.push_back(1'b0); lst.push_back(1'b0); lst.push_back(1'b1);
        run_vec("after_backpressure", sc, lst, 0);
    endtask

    task automatic test_single_element();
        sc_t sc[$]; bit lst[$];
        sc.push_back(sc_t'(42)); lst.push_back(1'b1);
        run_vec("single", sc, lst, 1);
    endtask

    task automatic test_reset_mid();
        sc_t sc[$]; bit lst[$];
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = (i == 4) ? sc_t'(50) : small_score(0, 40); in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if ({in_ready, out_valid, out_index, out_letter, out_err} !== '0 || out_max !== '0) begin
            fails++; $display("FAIL mid_reset: rdy=%b v=%b idx=%0d let=%h err=%b max=%0d need all 0",
                              in_ready, out_valid, out_index, out_letter, out_err, out_max);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NC; i++) begin
            sc.push_back(i == 1 ? sc_t'(7) : small_score(-20, 6)); lst.push_back(i == NC - 1);
        end
        run_vec("post_reset", sc, lst, 0);
    endtask

    task automatic test_random();
        sc_t sc[$]; bit lst[$];
        int len;
        for (int n = 0; n < 10; n++) begin
            sc.delete(); lst.delete();
            len = 1 + int'($urandom_range(NC - 1));
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(3))
                    0:       sc.push_back(wide_score());
                    1:       sc.push_back(small_score(-1000, -1));
                    default: sc.push_back(small_score(-40, 40));
                endcase
                lst.push_back((i == len - 1) && !(len == NC && $urandom_range(1) == 1));
            end
            run_vec($sformatf("random%0d", n), sc, lst, int'($urandom_range(3)));
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_tie();
        test_all_negative();
        test_length_err();
        test_backpressure();
        test_single_element();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/argmax_letter_decoder.md
Name: argmax_letter_decoder

Overview:
- Sequential classifier back-end that sits directly downstream of the final dense layer, the one configured to emit its full output vector.
- Accepts the layer's class scores one element per cycle over a valid/ready stream and applies ReLU clamping.
- Tracks the running maximum and emits the winning class index plus its ASCII letter (0-A, 1-B, …) with its own valid/ready handshake.
- Replaces the combinational in-layer max search with a clocked, back-pressurable stage.

Parameters:
- DBW, 234: score MSB index; each score is signed [DBW:0], matching dense output width OBW+1.
- NUM_CLASSES, 26: elements per vector (letters A–Z).
- IDXW, 6: class index width; must satisfy 2**IDXW >= NUM_CLASSES.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: in_data/in_last valid.
- in_ready, output, 1: block can accept an element.
- in_data, input, DBW+1: signed class score.
- in_last, input, 1: marks the final element of a vector.
- out_valid, output, 1: result available.
- out_ready, input, 1: consumer accepts the result.
- out_index, output, IDXW: index of the winning class.
- out_letter, output, 8: ASCII letter of out_index.
- out_max, output, DBW+1: winning score after ReLU (always >= 0).
- out_err, output, 1: vector length mismatch detected.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_index=0, out_letter=0, out_max=0, out_err=0.
  - Internal cnt=0, run_max=0, run_idx=0, state=IDLE.
  - in_ready=0 while rst is high; in_ready=1 on the first cycle after release.
- States:
  - IDLE: no vector in progress; in_ready=1.
  - SCAN: vector in progress; in_ready=1.
  - HOLD: result presented; in_ready=0, out_valid=1.
- Accept condition: an element is accepted when in_valid && in_ready. Nothing else changes state in IDLE or SCAN.
- Per accepted element:
  - val = (in_data < 0) ? 0 : in_data, using a signed compare.
  - The element's index is cnt. The first element of a vector (from IDLE) compares against max 0, index 0.
  - If val > current max (strictly greater), update run_max=val and run_idx=cnt.
  - Ties keep the lower index. An all-nonpositive vector yields index 0 and max 0.
- Vector termination: the vector closes on the accepted element where in_last=1 OR cnt==NUM_CLASSES-1.
  - out_err=1 if exactly one of those two conditions holds (early last, or missing last); 0 otherwise.
  - On close, the next edge sets state=HOLD and registers out_index, out_max, out_letter and out_err from the final comparison, which includes the closing element. cnt returns to 0.
  - Latency: out_valid rises 1 cycle after the closing element is accepted.
  - With NUM_CLASSES back-to-back elements, out_valid appears NUM_CLASSES cycles after the first accept.
- Transitions:
  - IDLE→SCAN on accept of a non-closing element.
  - IDLE→HOLD on accept of a closing element (e.g. in_last on the first element → 1-element vector).
  - SCAN→HOLD on the closing accept.
  - HOLD→IDLE on out_valid && out_ready. out_valid falls on the next edge, and in_ready rises the same cycle it falls.
- Output stability: while out_valid=1 and out_ready=0, all out_* signals hold stable for any number of cycles.
- Letter mapping: out_letter = 8'h41 + out_index if out_index < 26, else 8'h3F ('?').
- Back-pressure: in_valid asserted during HOLD is not accepted, and upstream must hold its data.
- Reset mid-vector or mid-HOLD: the partial vector or pending result is discarded and all values return to the reset values above. The next accept starts a fresh vector at index 0.
- Arithmetic: compare only, signed DBW+1 bits. No accumulation and no overflow paths.

Test Plan:
- Scores 0..25 ascending, in_last on the 26th, out_ready=1 → out_index=25, out_letter=8'h5A, out_max=25, out_err=0, out_valid 1 cycle after the last accept.
- Score 100 at indices 3 and 7, all others 5 → out_index=3, out_letter=8'h44 (tie keeps the lower index).
- All 26 scores = -9 → out_index=0, out_letter=8'h41, out_max=0, out_err=0.
- in_last on the 5th element with max at index 2 → result issued after 5 elements, out_index=2, out_err=1. Then 26 elements with no in_last → closes at the 26th, out_err=1.
- out_ready=0 for 10 cycles after out_valid, with in_valid held high → in_ready=0 throughout and outputs stable; out_ready pulse → out_valid=0 next cycle, the next vector is accepted from index 0.
- rst pulsed after 12 elements accepted (max 50 at index 4) → outputs 0; a fresh 26-element vector with max 7 at index 1 → out_index=1, out_max=7.
